// File: rtl/myenc_pkg.sv
// myenc_pkg: shared defaults and helpers for the encoder-speed measurement block.
package myenc_pkg;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_WINDOW_CYCLES = 256;
    localparam int CNT_MAX = 2 ** DEF_CNT_W - 1;
    function automatic int clog2(input int v);
        int r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/myenc_if.sv
// myenc_if: encoder channel input and speed reading bundle.
interface myenc_if import myenc_pkg::*; #(parameter int CNT_W = DEF_CNT_W);
    logic clocka;
    logic [CNT_W-1:0] oc;
    modport master (output clocka, input oc);
    modport slave (input clocka, output oc);
endinterface

// File: rtl/myenc_sync_edge.sv
// myenc_sync_edge: 2-flop synchronizer, optional glitch filter (MYENC_FILTER_EN), rising-edge pulse.
module myenc_sync_edge
`ifdef MYENC_FILTER_EN
    #(parameter int FILTER_LEN = 4)
`endif
(
    input  logic cloc,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);
    logic s1, s2, lvl, prev;
    always_ff @(posedge cloc or negedge rst_n)
        if (!rst_n) {s1, s2, prev} <= '0;
        else {s1, s2, prev} <= {raw, s1, lvl};
`ifdef MYENC_FILTER_EN
    import myenc_pkg::*;
    localparam int FW = clog2(FILTER_LEN) + 1;
    logic [FW-1:0] run;
    // run counts consecutive synced samples that disagree with the filtered level
    always_ff @(posedge cloc or negedge rst_n)
        if (!rst_n) begin
            lvl <= 1'b0;
            run <= '0;
        end else if (s2 == lvl) begin
            run <= '0;
        end else if (run == FW'(FILTER_LEN - 1)) begin
            lvl <= s2;
            run <= '0;
        end else begin
            run <= run + 1'b1;
        end
`else
    assign lvl = s2;
`endif
    assign rise = lvl & ~prev;
endmodule

// File: rtl/myenc.sv
// myenc: counts encoder channel-A rising edges per WINDOW_CYCLES window; oc holds the last closed window.
// Define MYENC_FILTER_EN to insert a FILTER_LEN-sample glitch filter before edge detection.
module myenc import myenc_pkg::*; #(
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int CNT_W = DEF_CNT_W
`ifdef MYENC_FILTER_EN
    , parameter int FILTER_LEN = 4
`endif
) (
    input logic cloc,
    input logic rst_n,
    myenc_if.slave bus
);
    localparam int WW = clog2(WINDOW_CYCLES);
    logic [WW-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt, sum;
    logic rise, last, full;
    myenc_sync_edge
`ifdef MYENC_FILTER_EN
        #(.FILTER_LEN(FILTER_LEN))
`endif
        u_sync (.cloc(cloc), .rst_n(rst_n), .raw(bus.clocka), .rise(rise));
    assign last = win_cnt == WW'(WINDOW_CYCLES - 1);
    assign full = &edge_cnt;
    // an edge on the terminal cycle still lands in the closing window
    assign sum = edge_cnt + CNT_W'(rise && !full);
    always_ff @(posedge cloc or negedge rst_n)
        if (!rst_n) begin
            win_cnt <= '0;
            edge_cnt <= '0;
            bus.oc <= '0;
        end else begin
            win_cnt <= last ? '0 : win_cnt + 1'b1;
            edge_cnt <= last ? '0 : sum;
            if (last) bus.oc <= sum;
        end
endmodule

// File: tb/tb_myenc.sv
// tb_myenc: scoreboard bench for myenc (256- and 1024-cycle windows sharing one encoder input).
module tb_myenc;
    import myenc_pkg::*;
`ifdef MYENC_FILTER_EN
    localparam int LAT = 7;
    localparam bit FILT = 1;
`else
    localparam int LAT = 3;
    localparam bit FILT = 0;
`endif
    localparam int W = 256;
    localparam int WB = 1024;
    logic cloc = 0, rst_n = 0, clocka = 0;
    int n_checks = 0, n_fail = 0, t = 0;
    int exp_a[$], exp_b[$];
    myenc_if #(.CNT_W(DEF_CNT_W)) bus_a();
    myenc_if #(.CNT_W(DEF_CNT_W)) bus_b();
    assign bus_a.clocka = clocka;
    assign bus_b.clocka = clocka;
    myenc #(.WINDOW_CYCLES(W), .CNT_W(DEF_CNT_W)) dut (.cloc(cloc), .rst_n(rst_n), .bus(bus_a));
    myenc #(.WINDOW_CYCLES(WB), .CNT_W(DEF_CNT_W)) dut_b (.cloc(cloc), .rst_n(rst_n), .bus(bus_b));
    always #5 cloc = ~cloc;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic run_to(input int tend, input int p, input int h);
        while (t < tend) begin
            clocka = p == 0 ? (h != 0) : ((t % p) < h);
            @(posedge cloc);
            #1 t++;
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        exp_a.delete();
        exp_b.delete();
        repeat (3) begin
            @(posedge cloc);
            #1 clocka = ~clocka;
        end
        @(negedge cloc);
        rst_n = 1;
        t = 0;
        clocka = 0;
    endtask

    task automatic test_reset();
        int e;
        rst_n = 0;
        repeat (6) begin
            @(posedge cloc);
            #1 clocka = ~clocka;
        end
        n_checks++;
        if (bus_a.oc !== 8'd0) begin n_fail++; $display("FAIL reset_oc: got %0d expected 0", bus_a.oc); end
        n_checks++;
        if (dut.edge_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_edge_cnt: got %0d expected 0", dut.edge_cnt); end
        n_checks++;
        if (dut.win_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_win_cnt: got %0d expected 0", dut.win_cnt); end
        n_checks++;
        if (bus_b.oc !== 8'd0) begin n_fail++; $display("FAIL reset_oc_b: got %0d expected 0", bus_b.oc); end
        @(negedge cloc);
        rst_n = 1;
        t = 0;
        exp_a.push_back(32);
        run_to(W - 1, 8, 4);
        n_checks++;
        if (bus_a.oc !== 8'd0) begin n_fail++; $display("FAIL first_window_early: got %0d expected 0", bus_a.oc); end
        run_to(W, 8, 4);
        e = exp_a.pop_front();
        n_checks++;
        if (bus_a.oc !== 8'(e)) begin n_fail++; $display("FAIL first_window: got %0d expected %0d", bus_a.oc, e); end
    endtask

    task automatic test_period8();
        int e;
        do_reset();
        repeat (3) exp_a.push_back(32);
        for (int k = 1; k <= 3; k++) begin
            run_to(k * W, 8, 4);
            e = exp_a.pop_front();
            n_checks++;
            if (bus_a.oc !== 8'(e)) begin n_fail++; $display("FAIL period8_win%0d: got %0d expected %0d", k, bus_a.oc, e); end
        end
        run_to(3 * W + 100, 8, 4);
        n_checks++;
        if (bus_a.oc !== 8'd32) begin n_fail++; $display("FAIL period8_hold: got %0d expected 32", bus_a.oc); end
    endtask

    task automatic test_fast();
        int e;
        do_reset();
        exp_a.push_back(FILT ? 0 : 127);
        repeat (7) exp_a.push_back(FILT ? 0 : 128);
        repeat (2) exp_b.push_back(FILT ? 0 : CNT_MAX);
        for (int k = 1; k <= 8; k++) begin
            run_to(k * W, 2, 1);
            e = exp_a.pop_front();
            n_checks++;
            if (bus_a.oc !== 8'(e)) begin n_fail++; $display("FAIL fast_win%0d: got %0d expected %0d", k, bus_a.oc, e); end
            if (k % 4 == 0) begin
                e = exp_b.pop_front();
                n_checks++;
                if (bus_b.oc !== 8'(e)) begin n_fail++; $display("FAIL saturate_win%0d: got %0d expected %0d", k / 4, bus_b.oc, e); end
            end
        end
    endtask

    task automatic test_idle();
        int e;
        do_reset();
        exp_a.push_back(32);
        exp_a.push_back(0);
        exp_a.push_back(0);
        run_to(250, 8, 4);
        for (int k = 1; k <= 3; k++) begin
            run_to(k * W, 0, 1);
            e = exp_a.pop_front();
            n_checks++;
            if (bus_a.oc !== 8'(e)) begin n_fail++; $display("FAIL idle_win%0d: got %0d expected %0d", k, bus_a.oc, e); end
        end
    endtask

    task automatic test_terminal();
        int e;
        for (int off = 0; off <= 1; off++) begin
            do_reset();
            exp_a.push_back(off == 0 ? 1 : 0);
            exp_a.push_back(off == 0 ? 0 : 1);
            run_to(W - LAT + off, 0, 0);
            for (int k = 1; k <= 2; k++) begin
                run_to(k * W, 0, 1);
                e = exp_a.pop_front();
                n_checks++;
                if (bus_a.oc !== 8'(e)) begin n_fail++; $display("FAIL terminal_off%0d_win%0d: got %0d expected %0d", off, k, bus_a.oc, e); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int e;
        do_reset();
        exp_a.push_back(32);
        run_to(W, 8, 4);
        e = exp_a.pop_front();
        n_checks++;
        if (bus_a.oc !== 8'(e)) begin n_fail++; $display("FAIL mid_pre: got %0d expected %0d", bus_a.oc, e); end
        run_to(W + 100, 8, 4);
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (bus_a.oc !== 8'd0) begin n_fail++; $display("FAIL mid_async_oc: got %0d expected 0", bus_a.oc); end
        n_checks++;
        if (dut.edge_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_async_cnt: got %0d expected 0", dut.edge_cnt); end
        @(negedge cloc);
        rst_n = 1;
        t = 0;
        exp_a.push_back(32);
        run_to(W - 1, 8, 4);
        n_checks++;
        if (bus_a.oc !== 8'd0) begin n_fail++; $display("FAIL mid_early: got %0d expected 0", bus_a.oc); end
        run_to(W, 8, 4);
        e = exp_a.pop_front();
        n_checks++;
        if (bus_a.oc !== 8'(e)) begin n_fail++; $display("FAIL mid_after: got %0d expected %0d", bus_a.oc, e); end
    endtask

`ifdef MYENC_FILTER_EN
    task automatic test_filter();
        int e;
        for (int h = 2; h <= 8; h += 6) begin
            do_reset();
            repeat (2) exp_a.push_back(h == 2 ? 0 : 16);
            for (int k = 1; k <= 2; k++) begin
                run_to(k * W, 16, h);
                e = exp_a.pop_front();
                n_checks++;
                if (bus_a.oc !== 8'(e)) begin n_fail++; $display("FAIL filter_h%0d_win%0d: got %0d expected %0d", h, k, bus_a.oc, e); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_period8();
        test_fast();
        test_idle();
        test_terminal();
        test_reset_mid();
`ifdef MYENC_FILTER_EN
        test_filter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
